// File: rtl/write_response_arbiter.sv
// Two-requester Avalon-MM burst write arbiter with in-order response routing.
// Define WRITE_RESPONSE_ARBITER_FIXED_PRIORITY_EN to make s0 always win contention.
module write_response_arbiter #(
  parameter int ADDRESS_WIDTH            = 48,
  parameter int DATA_WIDTH               = 512,
  parameter int BURST_WIDTH              = 3,
  parameter int MAX_PENDING_WRITES_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDRESS_WIDTH-1:0] s0_address,
  input  logic [DATA_WIDTH-1:0]    s0_writedata,
  input  logic                     s0_write,
  input  logic [DATA_WIDTH/8-1:0]  s0_byteenable,
  input  logic [BURST_WIDTH-1:0]   s0_burst,
  output logic                     s0_waitrequest,
  output logic [1:0]               s0_response,
  output logic                     s0_write_response_valid,
  input  logic [ADDRESS_WIDTH-1:0] s1_address,
  input  logic [DATA_WIDTH-1:0]    s1_writedata,
  input  logic                     s1_write,
  input  logic [DATA_WIDTH/8-1:0]  s1_byteenable,
  input  logic [BURST_WIDTH-1:0]   s1_burst,
  output logic                     s1_waitrequest,
  output logic [1:0]               s1_response,
  output logic                     s1_write_response_valid,
  output logic [ADDRESS_WIDTH-1:0] m_address,
  output logic [DATA_WIDTH-1:0]    m_writedata,
  output logic                     m_write,
  output logic [DATA_WIDTH/8-1:0]  m_byteenable,
  output logic [BURST_WIDTH-1:0]   m_burst,
  input  logic                     m_waitrequest,
  input  logic [1:0]               m_response,
  input  logic                     m_write_response_valid,
  output logic                     error
);

  localparam int CNT_W = MAX_PENDING_WRITES_WIDTH;
  localparam int PTR_W = CNT_W - 1;
  localparam int DEPTH = 1 << PTR_W;

  logic                   lock_q, lock_d;
  logic                   owner_q, owner_d;
  logic [BURST_WIDTH-1:0] beats_q, beats_d;
  logic [DEPTH-1:0]       ids_q;
  logic [PTR_W-1:0]       wr_q, rd_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   err_q;
  logic                   rv0_q, rv1_q;
  logic [1:0]             rsp0_q, rsp1_q;

  logic                   sel;
  logic                   pri;
  logic                   sel_write;
  logic [BURST_WIDTH-1:0] sel_burst;
  logic                   full;
  logic                   block;
  logic                   accept;
  logic                   first;
  logic                   push;
  logic                   pop;
  logic                   head;

`ifdef WRITE_RESPONSE_ARBITER_FIXED_PRIORITY_EN
  assign pri = 1'b0;
`else
  logic ptr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= 1'b0;
    end else if (first) begin
      ptr_q <= ~sel;
    end
  end

  assign pri = ptr_q;
`endif

  always_comb begin
    sel = 1'b0;
    if (lock_q) begin
      sel = owner_q;
    end else if (s0_write && s1_write) begin
      sel = pri;
    end else if (s1_write) begin
      sel = 1'b1;
    end
  end

  assign sel_write = sel ? s1_write : s0_write;
  assign sel_burst = sel ? s1_burst : s0_burst;
  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign block     = ~lock_q & full;

  assign m_address    = sel ? s1_address : s0_address;
  assign m_writedata  = sel ? s1_writedata : s0_writedata;
  assign m_byteenable = sel ? s1_byteenable : s0_byteenable;
  assign m_burst      = sel_burst;
  // Reset gating keeps the master quiet while reset_n is held low.
  assign m_write      = sel_write & ~block & reset_n;

  assign s0_waitrequest = ~reset_n | sel | m_waitrequest | block;
  assign s1_waitrequest = ~reset_n | ~sel | m_waitrequest | block;

  assign accept = m_write & ~m_waitrequest;
  assign first  = accept & ~lock_q;
  assign push   = first;
  assign pop    = m_write_response_valid & (cnt_q != '0);
  assign head   = ids_q[rd_q];

  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    beats_d = beats_q;
    if (first && (sel_burst > BURST_WIDTH'(1))) begin
      lock_d  = 1'b1;
      owner_d = sel;
      beats_d = sel_burst - BURST_WIDTH'(1);
    end else if (accept && lock_q) begin
      beats_d = beats_q - BURST_WIDTH'(1);
      if (beats_q == BURST_WIDTH'(1)) begin
        lock_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q  <= 1'b0;
      owner_q <= 1'b0;
      beats_q <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      beats_q <= beats_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ids_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        ids_q[wr_q] <= sel;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rv0_q  <= 1'b0;
      rv1_q  <= 1'b0;
      rsp0_q <= 2'b00;
      rsp1_q <= 2'b00;
      err_q  <= 1'b0;
    end else begin
      rv0_q <= pop & ~head;
      rv1_q <= pop & head;
      if (pop && !head) begin
        rsp0_q <= m_response;
      end
      if (pop && head) begin
        rsp1_q <= m_response;
      end
      if (m_write_response_valid && (cnt_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign s0_write_response_valid = rv0_q;
  assign s1_write_response_valid = rv1_q;
  assign s0_response             = rsp0_q;
  assign s1_response             = rsp1_q;
  assign error                   = err_q;

endmodule

// File: doc/write_response_arbiter.md
# write_response_arbiter

Two-requester Avalon-MM bursting write arbiter that shares one write master port, typically the slave side of the write response bridge, between two DMA write engines. It grants whole bursts, holds the grant until the last beat is accepted, and records requester IDs in issue order. Each write response returned by the master port is then routed to the requester that issued the burst. It also throttles new bursts when the ID tracker is full.

## Interface
- ADDRESS_WIDTH, 48, address width
- DATA_WIDTH, 512, data width; byteenable is DATA_WIDTH/8
- BURST_WIDTH, 3, 1+log2(max burst); max burst is a power of 2
- MAX_PENDING_WRITES_WIDTH, 6, 1+log2(ID FIFO depth); depth = 2^(MAX_PENDING_WRITES_WIDTH-1) = 32

Ports:
- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- s0_address / s1_address  in  ADDRESS_WIDTH  requester address
- s0_writedata / s1_writedata  in  DATA_WIDTH  requester write data
- s0_write / s1_write  in  1  requester write request
- s0_byteenable / s1_byteenable  in  DATA_WIDTH/8  requester byte enables
- s0_burst / s1_burst  in  BURST_WIDTH  burst length; sampled on the first beat only
- s0_waitrequest / s1_waitrequest  out  1  backpressure to the requester
- s0_response / s1_response  out  2  routed write response code
- s0_write_response_valid / s1_write_response_valid  out  1  routed write response strobe
- m_address, m_writedata, m_write, m_byteenable, m_burst  out  widths as above  muxed master command
- m_waitrequest  in  1  master backpressure
- m_response  in  2  master write response code
- m_write_response_valid  in  1  master write response strobe
- error  out  1  sticky; set when a response arrives while the ID FIFO is empty

## Operation
- State: lock (1b), owner (1b), beats_left (BURST_WIDTH), priority pointer ptr (1b), ID FIFO with count (MAX_PENDING_WRITES_WIDTH).
- Selection when lock=0 is combinational:
  - One requester writing: it is selected.
  - Both writing: requester ptr is selected.
  - The selected requester's first beat passes through in the same cycle.
- Selection when lock=1: sel = owner.
- m_* = selected requester's command. m_write = sel_write & ~block, where block = ~lock & fifo_full.
- Waitrequest:
  - Selected requester: m_waitrequest | block.
  - Non-selected requester: 1.
- A beat is accepted when m_write=1 and m_waitrequest=0.
- Accepted first beat (lock=0):
  - Push sel into the ID FIFO.
  - ptr <= ~sel.
  - If burst > 1: lock <= 1, owner <= sel, beats_left <= burst-1.
- Accepted beat while lock=1: beats_left decrements. When it reaches 0 after the last beat, lock <= 0.
- Response routing: on m_write_response_valid, pop the FIFO head and deliver to that requester one cycle later.
  - s{head}_write_response_valid <= 1 and s{head}_response <= m_response, registered.
  - The other requester's valid stays 0.
- Response with the FIFO empty: the response is dropped, no valid is driven, and error <= 1. Only reset clears error.
- Push and pop in the same cycle: count is unchanged.
- FIFO full (count == depth): new bursts are blocked even if a pop occurs that cycle. Beats of a locked burst continue.
- Burst value 0 is treated as 1.

## Timing
- Reset values (asynchronous, while reset_n=0):
  - Registers: lock=0, ptr=0, FIFO empty, error=0.
  - Outputs: m_write=0, s0/s1_waitrequest=1, s0/s1_write_response_valid=0, s0/s1_response=0.
- Command path: 0-cycle combinational latency from requester to master.
- Response path: exactly 1 cycle from m_write_response_valid to s*_write_response_valid. Back-to-back responses are supported every cycle.
- Arbitration is re-evaluated only between bursts. No idle cycle is inserted between bursts from different requesters.
- Reset during a burst: the burst is abandoned and tracked IDs are discarded. The first request after reset_n rises starts a new burst with s0 having priority.

## Configuration
- WRITE_RESPONSE_ARBITER_FIXED_PRIORITY_EN
  - Defined: s0 always wins contention at burst start; ptr is not implemented.
  - Undefined: round-robin behaviour as specified above.

## Test plan
- s0 burst=4 and s1 burst=2 asserted together from reset → s0 receives 4 beats, then s1 receives 2 beats; s1_waitrequest=1 throughout s0's burst; FIFO holds {0,1}.
- Two responses with m_response=2'b00 then 2'b10 → s0_write_response_valid pulses with 00, then s1_write_response_valid pulses with 10, each 1 cycle after its input.
- 32 single-beat writes from s1 with no responses → the 33rd write sees s1_waitrequest=1 and m_write=0. One response arrives: the write is still blocked that cycle and accepted the next cycle.
- m_waitrequest=1 for 3 cycles mid-burst on s0 burst=4 → beats hold, owner unchanged, exactly 4 beats accepted in total, lock released after the last beat.
- m_write_response_valid with the FIFO empty → no s*_write_response_valid; error=1 and stays 1 until reset_n=0.
- reset_n low after 2 of 4 beats → m_write=0 immediately, both waitrequests=1; after release, s1 burst=1 is accepted with FIFO count=1.
